mem_dp_param: RTL

MEM_DP_PARAM -- requirements
Module: mem_dp_param

---
 rtl/mem_pkg.sv | 19 +
 rtl/mem_dp_array.sv | 36 +++
 rtl/mem_dp_param.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the dual-port byte-masked memory.
// State encodings, default geometry and a lane-count helper.
package mem_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 9;

    typedef enum logic [1:0] {
        RESET = 2'd0,
        INIT  = 2'd1,
        RUN   = 2'd2
    } state_t;

    // Number of 8-bit byte lanes in a data word.
    function automatic int num_lanes(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/mem_dp_array.sv
// Storage array: one write port with per-byte-lane mask, one registered
// read port returning the pre-write (old) contents. Each byte lane owns its
// own storage so lanes are written independently.
module mem_dp_array
    import mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                   i_clk,
    input  logic                   i_we,
    input  logic [ADDR_W-1:0]      i_waddr,
    input  logic [DATA_W-1:0]      i_wdata,
    input  logic [DATA_W/8-1:0]    i_wmask,
    input  logic                   i_re,
    input  logic [ADDR_W-1:0]      i_raddr,
    output logic [DATA_W-1:0]      o_rdata
);

    localparam int NL    = num_lanes(DATA_W);
    localparam int DEPTH = 2 ** ADDR_W;

    for (genvar n = 0; n < NL; n++) begin : g_lane
        logic [7:0] mem [DEPTH];
        logic [7:0] rd_q;

        // Lane write plus registered lane read (read sees old contents).
        always_ff @(posedge i_clk) begin
            if (i_we && i_wmask[n]) mem[i_waddr] <= i_wdata[8*n +: 8];
            if (i_re)               rd_q         <= mem[i_raddr];
        end

        assign o_rdata[8*n +: 8] = rd_q;
    end

endmodule

// File: rtl/mem_dp_param.sv
// Dual-port byte-masked memory with init sequencing.
// Optional feature macro: MEM_INIT_CLEAR_EN -- when defined the block walks
// every address writing zero before accepting traffic; otherwise it is ready
// one edge after reset release with undefined contents.
// Same-address read+write returns new data per written lane (write-first).
module mem_dp_param
    import mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                   i_clk,
    input  logic                   i_nrst,
    input  logic                   i_we,
    input  logic [ADDR_W-1:0]      i_waddr,
    input  logic [DATA_W-1:0]      i_wdata,
    input  logic [DATA_W/8-1:0]    i_wmask,
    input  logic                   i_re,
    input  logic [ADDR_W-1:0]      i_raddr,
    output logic [DATA_W-1:0]      o_rdata,
    output logic                   o_rvalid,
    output logic                   o_ready
);

    localparam int NL = num_lanes(DATA_W);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   init_cnt_q;
    logic                ready;
    logic                rd_acc;

    logic                arr_we;
    logic [ADDR_W-1:0]   arr_waddr;
    logic [DATA_W-1:0]   arr_wdata;
    logic [NL-1:0]       arr_wmask;
    logic [DATA_W-1:0]   arr_rdata;

    logic [NL-1:0]       byp_mask_q;
    logic [DATA_W-1:0]   byp_data_q;
    logic                rvalid_q;
    logic [DATA_W-1:0]   rdata_hold_q;
    logic [DATA_W-1:0]   merged;

    assign ready   = (state_q == RUN);
    assign rd_acc  = ready & i_re;
    assign o_ready = ready;

    // State register.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) state_q <= RESET;
        else         state_q <= state_d;
    end

    // Next-state: RESET leaves on the first edge, RUN holds until reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RESET: begin
`ifdef MEM_INIT_CLEAR_EN
                state_d = INIT;
`else
                state_d = RUN;
`endif
            end
            INIT:    if (init_cnt_q == '1) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = RESET;
        endcase
    end

    // Init address walker, one word per cycle while in INIT.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst)              init_cnt_q <= '0;
        else if (state_q == INIT) init_cnt_q <= init_cnt_q + 1'b1;
    end

    // Write port mux: INIT clears full words, RUN passes user writes.
    always_comb begin
        arr_we    = 1'b0;
        arr_waddr = i_waddr;
        arr_wdata = i_wdata;
        arr_wmask = i_wmask;
        if (state_q == INIT) begin
            arr_we    = 1'b1;
            arr_waddr = init_cnt_q;
            arr_wdata = '0;
            arr_wmask = '1;
        end else if (ready) begin
            arr_we    = i_we;
        end
    end

    mem_dp_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .i_clk   (i_clk),
        .i_we    (arr_we),
        .i_waddr (arr_waddr),
        .i_wdata (arr_wdata),
        .i_wmask (arr_wmask),
        .i_re    (rd_acc),
        .i_raddr (i_raddr),
        .o_rdata (arr_rdata)
    );

    // Capture collision lanes so the read returns this cycle's write data.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            byp_mask_q <= '0;
            byp_data_q <= '0;
        end else if (rd_acc) begin
            byp_mask_q <= (i_we && (i_waddr == i_raddr)) ? i_wmask : '0;
            byp_data_q <= i_wdata;
        end
    end

    // Read valid strobe, one cycle after acceptance.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) rvalid_q <= 1'b0;
        else         rvalid_q <= rd_acc;
    end

    // Per-lane merge of array data with bypassed write data.
    always_comb begin
        merged = arr_rdata;
        for (int n = 0; n < NL; n++)
            if (byp_mask_q[n]) merged[8*n +: 8] = byp_data_q[8*n +: 8];
    end

    // Hold last delivered read word between reads.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst)       rdata_hold_q <= '0;
        else if (rvalid_q) rdata_hold_q <= merged;
    end

    assign o_rdata  = rvalid_q ? merged : rdata_hold_q;
    assign o_rvalid = rvalid_q;

endmodule
